// File: rtl/keypad_scanner_pkg.sv
// Shared keypad geometry and helpers, also used by the game core and matrix display.
package keypad_scanner_pkg;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = NUM_ROWS * NUM_COLS;
    localparam int CODE_W   = $clog2(KEY_W);

    typedef enum logic [1:0] {ROW0, ROW1, ROW2, ROW3} row_e;

    // Bit position of a key in the 16-bit key vector.
    function automatic logic [CODE_W-1:0] key_idx(input logic [1:0] row, input logic [1:0] col);
        return CODE_W'(int'(row) * NUM_COLS + int'(col));
    endfunction

    function automatic logic [CODE_W-1:0] lowest_set(input logic [KEY_W-1:0] v);
        logic [CODE_W-1:0] r;
        r = '0;
        for (int i = KEY_W - 1; i >= 0; i--)
            if (v[i]) r = CODE_W'(i);
        return r;
    endfunction
endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for the asynchronous column inputs; idles high like the pull-ups.
module keypad_scanner_sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_ff1, r_ff2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ff1 <= '1;
            r_ff2 <= '1;
        end else begin
            r_ff1 <= i_d;
            r_ff2 <= r_ff1;
        end
    end

    assign o_q = r_ff2;
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with frame-level debounce and a one-cycle new-press pulse.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV        = 50_000,
    parameter int DEBOUNCE_FRAMES = 5
) (
    input  logic              clk,
    input  logic              rst,
    output logic [3:0]        row_out,
    input  logic [3:0]        col_in,
    output logic [KEY_W-1:0]  key,
    output logic              press,
    output logic [CODE_W-1:0] press_code
);
    localparam int              CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [2:0]      STAB_MAX = 3'(DEBOUNCE_FRAMES - 1);

    logic [NUM_COLS-1:0] w_col_n;
    logic [CNT_W-1:0]    r_slot;
    row_e                r_row, w_row_nxt;
    logic [3:0]          r_row_out, w_row_drv;
    logic                w_slot_tc, w_frame_done, w_load;
    logic [KEY_W-1:0]    r_raw, r_prev, r_key, w_frame, w_new;
    logic [2:0]          r_stab, w_stab_nxt;
    logic                r_press;
    logic [CODE_W-1:0]   r_code;

    keypad_scanner_sync2 #(.W(NUM_COLS)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (col_in),
        .o_q (w_col_n)
    );

    assign w_slot_tc = (r_slot == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) r_row <= ROW0;
        else     r_row <= w_row_nxt;
    end

    always_comb begin
        w_row_nxt = r_row;
        if (w_slot_tc) w_row_nxt = row_e'(2'(r_row) + 2'd1);
    end

    always_comb begin
        w_row_drv    = ~(4'b0001 << w_row_nxt);
        w_frame_done = w_slot_tc && (r_row == ROW3);
    end

    // The row-3 sample is merged in combinationally so the frame is judged on the cycle it completes.
    always_comb begin
        w_frame = r_raw;
        w_frame[key_idx(r_row, 2'd0) +: NUM_COLS] = ~w_col_n;
    end

    always_comb begin
        w_stab_nxt = 3'd0;
        if (w_frame == r_prev) w_stab_nxt = (r_stab == STAB_MAX) ? r_stab : r_stab + 3'd1;
    end

    assign w_load = w_frame_done && (w_stab_nxt == STAB_MAX);
    assign w_new  = w_frame & ~r_key;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot    <= '0;
            r_row_out <= 4'b1110;
            r_raw     <= '0;
            r_prev    <= '0;
            r_stab    <= '0;
            r_key     <= '0;
            r_press   <= 1'b0;
            r_code    <= '0;
        end else begin
            r_slot    <= w_slot_tc ? '0 : r_slot + 1'b1;
            r_row_out <= w_row_drv;
            if (w_slot_tc) r_raw <= w_frame;
            if (w_frame_done) begin
                r_prev <= w_frame;
                r_stab <= w_stab_nxt;
            end
            if (w_load) r_key <= w_frame;
            r_press <= w_load && (|w_new);
            if (w_load && (|w_new)) r_code <= lowest_set(w_new);
        end
    end

    assign row_out    = r_row_out;
    assign key        = r_key;
    assign press      = r_press;
    assign press_code = r_code;
endmodule
